// File: rtl/alu_result_stage_if.sv
// Handshake bundle for the ALU result stage: upstream result set in, selected result out.
// The master side is the environment (upstream + downstream); the slave side is the stage itself.
interface alu_result_stage_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5,
  parameter int CNT_W = 16
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_sel;
  logic [WIDTH-1:0] in_arith;
  logic [WIDTH-1:0] in_logic;
  logic [WIDTH-1:0] in_shift;
  logic             in_slt;
  logic             in_sltu;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_zero;
  logic             out_illegal;
  logic [TAG_W-1:0] out_tag;
  logic [CNT_W-1:0] out_count;

  modport master (
    output flush, in_valid, in_sel, in_arith, in_logic, in_shift, in_slt, in_sltu, in_tag,
    output out_ready,
    input  in_ready, out_valid, out_result, out_zero, out_illegal, out_tag, out_count
  );

  modport slave (
    input  flush, in_valid, in_sel, in_arith, in_logic, in_shift, in_slt, in_sltu, in_tag,
    input  out_ready,
    output in_ready, out_valid, out_result, out_zero, out_illegal, out_tag, out_count
  );
endinterface

// File: rtl/alu_result_stage.sv
// ALU result select with zero/illegal flags, 2-entry skid buffer and a saturating
// delivered-result counter. All outputs come straight from registers.
module alu_result_stage #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5,
  parameter int CNT_W = 16
) (
  input logic             clk,
  input logic             rst_n,
  alu_result_stage_if.slave bus
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam entry_t           ENTRY_ZERO = {$bits(entry_t){1'b0}};

  state_t           state_r;
  entry_t           main_r;
  entry_t           skid_r;
  logic             out_valid_r;
  logic             in_ready_r;
  logic [CNT_W-1:0] count_r;

  logic [WIDTH-1:0] sel_result_s;
  logic             sel_illegal_s;
  entry_t           sel_entry_s;
  logic             accept_s;
  logic             deliver_s;

  // Result mux; codes 101-111 are illegal and force a zero result.
  always_comb begin
    sel_result_s  = {WIDTH{1'b0}};
    sel_illegal_s = 1'b0;
    case (bus.in_sel)
      3'b000:  sel_result_s = bus.in_arith;
      3'b001:  sel_result_s = bus.in_logic;
      3'b010:  sel_result_s = bus.in_shift;
      3'b011:  sel_result_s = {{(WIDTH-1){1'b0}}, bus.in_slt};
      3'b100:  sel_result_s = {{(WIDTH-1){1'b0}}, bus.in_sltu};
      default: sel_illegal_s = 1'b1;
    endcase
  end

  assign sel_entry_s.result  = sel_result_s;
  assign sel_entry_s.zero    = (sel_result_s == {WIDTH{1'b0}});
  assign sel_entry_s.illegal = sel_illegal_s;
  assign sel_entry_s.tag     = bus.in_tag;

  // in_ready_r is the registered image of "skid empty", so out_ready never reaches in_ready.
  assign accept_s  = bus.in_valid & in_ready_r;
  assign deliver_s = out_valid_r & bus.out_ready;

  // Skid-buffer state machine, storage and delivered-result counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_EMPTY;
      main_r      <= ENTRY_ZERO;
      skid_r      <= ENTRY_ZERO;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
      count_r     <= {CNT_W{1'b0}};
    end else begin
      // A deliver in the flush cycle was already seen downstream, so it still counts.
      if (deliver_s && (count_r != CNT_MAX)) begin
        count_r <= count_r + CNT_ONE;
      end else begin
        count_r <= count_r;
      end

      if (bus.flush) begin
        state_r     <= ST_EMPTY;
        out_valid_r <= 1'b0;
        in_ready_r  <= 1'b1;
      end else begin
        case (state_r)
          ST_EMPTY: begin
            if (accept_s) begin
              main_r      <= sel_entry_s;
              state_r     <= ST_ONE;
              out_valid_r <= 1'b1;
            end
          end
          ST_ONE: begin
            if (accept_s && !deliver_s) begin
              skid_r     <= sel_entry_s;
              state_r    <= ST_FULL;
              in_ready_r <= 1'b0;
            end else if (accept_s && deliver_s) begin
              main_r <= sel_entry_s;
            end else if (deliver_s) begin
              state_r     <= ST_EMPTY;
              out_valid_r <= 1'b0;
            end
          end
          ST_FULL: begin
            if (deliver_s) begin
              main_r     <= skid_r;
              state_r    <= ST_ONE;
              in_ready_r <= 1'b1;
            end
          end
          default: begin
            state_r     <= ST_EMPTY;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.in_ready    = in_ready_r;
  assign bus.out_valid   = out_valid_r;
  assign bus.out_result  = main_r.result;
  assign bus.out_zero    = main_r.zero;
  assign bus.out_illegal = main_r.illegal;
  assign bus.out_tag     = main_r.tag;
  assign bus.out_count   = count_r;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: reset, select, streaming, backpressure,
// flush, mid-stream reset and counter saturation (second instance with CNT_W=4).
module tb_alu_result_stage;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  alu_result_stage_if #(.WIDTH(32), .TAG_W(5), .CNT_W(16)) b0 ();
  alu_result_stage_if #(.WIDTH(32), .TAG_W(5), .CNT_W(4))  b1 ();

  alu_result_stage #(.WIDTH(32), .TAG_W(5), .CNT_W(16)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b0.slave)
  );

  alu_result_stage #(.WIDTH(32), .TAG_W(5), .CNT_W(4)) u_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] sel, input logic [31:0] arith,
                       input logic [31:0] lg, input logic [31:0] sh,
                       input logic slt, input logic sltu, input logic [4:0] tag);
    b0.in_valid = v;
    b0.in_sel   = sel;
    b0.in_arith = arith;
    b0.in_logic = lg;
    b0.in_shift = sh;
    b0.in_slt   = slt;
    b0.in_sltu  = sltu;
    b0.in_tag   = tag;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] res, input logic zero,
                         input logic ill, input logic [4:0] t);
    chk({tag, "_valid"},   b0.out_valid,   1'b1);
    chk({tag, "_result"},  b0.out_result,  res);
    chk({tag, "_zero"},    b0.out_zero,    zero);
    chk({tag, "_illegal"}, b0.out_illegal, ill);
    chk({tag, "_tag"},     b0.out_tag,     t);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    b0.flush = 1'b0;
    b0.out_ready = 1'b0;
    drive(1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0);
    b1.flush = 1'b0; b1.in_valid = 1'b0; b1.in_sel = 3'b000; b1.in_arith = 32'h0;
    b1.in_logic = 32'h0; b1.in_shift = 32'h0; b1.in_slt = 1'b0; b1.in_sltu = 1'b0;
    b1.in_tag = 5'd0; b1.out_ready = 1'b0;

    // Reset state
    tick();
    chk("rst_out_valid", b0.out_valid, 1'b0);
    chk("rst_in_ready", b0.in_ready, 1'b1);
    chk("rst_result", b0.out_result, 32'h0);
    chk("rst_zero", b0.out_zero, 1'b0);
    chk("rst_illegal", b0.out_illegal, 1'b0);
    chk("rst_tag", b0.out_tag, 5'd0);
    chk("rst_count", b0.out_count, 16'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Select: arith, SLT, SLTU, illegal, logic, shift back to back
    b0.out_ready = 1'b1;
    drive(1'b1, 3'b000, 32'h0000_0005, 32'hFFFF_FFFF, 32'h1, 1'b1, 1'b1, 5'd1);
    tick(); chk_out("sel_arith", 32'h5, 1'b0, 1'b0, 5'd1);
    drive(1'b1, 3'b011, 32'hDEAD_BEEF, 32'h0, 32'h0, 1'b1, 1'b0, 5'd2);
    tick(); chk_out("sel_slt", 32'h1, 1'b0, 1'b0, 5'd2);
    drive(1'b1, 3'b100, 32'hDEAD_BEEF, 32'h0, 32'h0, 1'b1, 1'b0, 5'd3);
    tick(); chk_out("sel_sltu", 32'h0, 1'b1, 1'b0, 5'd3);
    drive(1'b1, 3'b110, 32'h0000_1234, 32'h5, 32'h6, 1'b1, 1'b1, 5'd4);
    tick(); chk_out("sel_illegal", 32'h0, 1'b1, 1'b1, 5'd4);
    drive(1'b1, 3'b001, 32'h1, 32'h0000_F0F0, 32'h2, 1'b0, 1'b0, 5'd5);
    tick(); chk_out("sel_logic", 32'h0000_F0F0, 1'b0, 1'b0, 5'd5);
    drive(1'b1, 3'b010, 32'h1, 32'h2, 32'h8000_0000, 1'b0, 1'b0, 5'd6);
    tick(); chk_out("sel_shift", 32'h8000_0000, 1'b0, 1'b0, 5'd6);
    drive(1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0);
    tick();
    chk("sel_drain_valid", b0.out_valid, 1'b0);
    chk("sel_count", b0.out_count, 16'd6);

    // Streaming: 16 back-to-back results with out_ready held high
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 3'b000, 32'h100 + 32'(i), 32'h0, 32'h0, 1'b0, 1'b0, 5'(i));
      tick();
      chk("stream_in_ready", b0.in_ready, 1'b1);
      chk("stream_valid", b0.out_valid, 1'b1);
      chk("stream_result", b0.out_result, 32'h100 + 32'(i));
      chk("stream_tag", b0.out_tag, 5'(i));
    end
    drive(1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0);
    tick();
    chk("stream_drain_valid", b0.out_valid, 1'b0);
    chk("stream_count", b0.out_count, 16'd22);

    // Backpressure: three pushes against a stalled output, only two land
    b0.out_ready = 1'b0;
    drive(1'b1, 3'b000, 32'hA1, 32'h0, 32'h0, 1'b0, 1'b0, 5'd10);
    tick();
    chk_out("bp_first", 32'hA1, 1'b0, 1'b0, 5'd10);
    chk("bp_ready_1", b0.in_ready, 1'b1);
    drive(1'b1, 3'b000, 32'hA2, 32'h0, 32'h0, 1'b0, 1'b0, 5'd11);
    tick();
    chk_out("bp_hold_1", 32'hA1, 1'b0, 1'b0, 5'd10);
    chk("bp_ready_full", b0.in_ready, 1'b0);
    drive(1'b1, 3'b000, 32'hA3, 32'h0, 32'h0, 1'b0, 1'b0, 5'd12);
    tick();
    chk_out("bp_hold_2", 32'hA1, 1'b0, 1'b0, 5'd10);
    chk("bp_ready_still", b0.in_ready, 1'b0);
    tick();
    chk_out("bp_hold_3", 32'hA1, 1'b0, 1'b0, 5'd10);
    drive(1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0);
    b0.out_ready = 1'b1;
    tick();
    chk_out("bp_second", 32'hA2, 1'b0, 1'b0, 5'd11);
    chk("bp_ready_back", b0.in_ready, 1'b1);
    tick();
    chk("bp_drain_valid", b0.out_valid, 1'b0);
    chk("bp_count", b0.out_count, 16'd24);

    // Flush with a FULL buffer and same-cycle accept/deliver
    b0.out_ready = 1'b0;
    drive(1'b1, 3'b000, 32'hB1, 32'h0, 32'h0, 1'b0, 1'b0, 5'd1);
    tick();
    drive(1'b1, 3'b000, 32'hB2, 32'h0, 32'h0, 1'b0, 1'b0, 5'd2);
    tick();
    chk("fl_full_ready", b0.in_ready, 1'b0);
    b0.flush = 1'b1;
    b0.out_ready = 1'b1;
    drive(1'b1, 3'b000, 32'hB3, 32'h0, 32'h0, 1'b0, 1'b0, 5'd3);
    tick();
    chk("fl_valid", b0.out_valid, 1'b0);
    chk("fl_ready", b0.in_ready, 1'b1);
    chk("fl_count", b0.out_count, 16'd25);
    b0.flush = 1'b0;
    drive(1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0);
    tick();
    chk("fl_discard_valid", b0.out_valid, 1'b0);
    chk("fl_count_hold", b0.out_count, 16'd25);

    // Asynchronous reset mid-stream with a FULL buffer
    b0.out_ready = 1'b0;
    drive(1'b1, 3'b000, 32'hC1, 32'h0, 32'h0, 1'b0, 1'b0, 5'd1);
    tick();
    drive(1'b1, 3'b000, 32'hC2, 32'h0, 32'h0, 1'b0, 1'b0, 5'd2);
    tick();
    chk("ar_full_ready", b0.in_ready, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", b0.out_valid, 1'b0);
    chk("ar_count", b0.out_count, 16'd0);
    chk("ar_ready", b0.in_ready, 1'b1);
    tick();
    chk("ar_held_valid", b0.out_valid, 1'b0);
    rst_n = 1'b1;
    b0.out_ready = 1'b1;
    drive(1'b1, 3'b000, 32'h33, 32'h0, 32'h0, 1'b0, 1'b0, 5'd7);
    tick();
    chk_out("ar_first", 32'h33, 1'b0, 1'b0, 5'd7);
    chk("ar_first_count", b0.out_count, 16'd0);
    drive(1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0);
    tick();
    chk("ar_after_count", b0.out_count, 16'd1);

    // Saturation on the CNT_W=4 instance: 20 delivers, counter stops at 15
    b1.out_ready = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      b1.in_valid = 1'b1;
      b1.in_arith = 32'(k);
      b1.in_tag   = 5'(k);
      tick();
      if (k == 10) chk("sat_mid_count", b1.out_count, 4'd9);
    end
    b1.in_valid = 1'b0;
    tick();
    chk("sat_drain_valid", b1.out_valid, 1'b0);
    chk("sat_count", b1.out_count, 4'd15);
    tick();
    chk("sat_count_hold", b1.out_count, 4'd15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
